// File: rtl/temp_alarm_fsm.sv
// temp_alarm_fsm: temperature alarm sequencer with BCD sample checking, persistence
// filtering, sign/rate fault detection and LED pattern drive.
//
// state  | meaning
// NORMAL | below warning band, LEDs off
// WARN   | warning level, alternating LED pattern
// CRIT   | critical level, all LEDs blinking
// FAULT  | sign flip or excessive rate, LEDs solid until ack
module temp_alarm_fsm #(
    parameter int                  DIGITS    = 3,
    parameter int                  LEDS      = 10,
    parameter logic [4*DIGITS-1:0] WARN_TH   = 12'h460,
    parameter logic [4*DIGITS-1:0] WARN_CLR  = 12'h450,
    parameter logic [4*DIGITS-1:0] CRIT_TH   = 12'h490,
    parameter logic [4*DIGITS-1:0] CRIT_CLR  = 12'h480,
    parameter logic [4*DIGITS-1:0] RATE_TH   = 12'h050,
    parameter int                  PERSIST   = 4,
    parameter int                  BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [4*DIGITS-1:0]   temp_bcd,
    input  logic                  temp_neg,
    input  logic [4*DIGITS-1:0]   rate_bcd,
    input  logic                  ack,
    output logic [LEDS-1:0]       alarm,
    output logic [1:0]            state,
    output logic                  bcd_err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(PERSIST + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] P_LAST = CW'(PERSIST - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        WARN   = 2'b01,
        CRIT   = 2'b10,
        FAULT  = 2'b11
    } state_t;

    function automatic logic bcd_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [LEDS-1:0] warn_pattern();
        logic [LEDS-1:0] p;
        for (int i = 0; i < LEDS; i++) p[i] = (((LEDS - 1 - i) % 2) == 0);
        return p;
    endfunction

    localparam logic [LEDS-1:0] WARN_PAT = warn_pattern();

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          sref_q, sref_d;
    logic          sref_valid_q, sref_valid_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          bcd_err_q;

    logic in_ok, accepted;
    logic gt_warn, gt_crit, le_wclr, le_cclr;
    logic rate_fault, sign_fault, fault_hit;
    logic cond_a, cond_b, hit, pend_n;
    state_t tgt_a, tgt_b;

    assign in_ok      = bcd_ok(temp_bcd) && bcd_ok(rate_bcd);
    assign accepted   = sample_valid && in_ok;
    // negative readings sit below every threshold
    assign gt_warn    = !temp_neg && (temp_bcd > WARN_TH);
    assign gt_crit    = !temp_neg && (temp_bcd > CRIT_TH);
    assign le_wclr    = temp_neg || (temp_bcd <= WARN_CLR);
    assign le_cclr    = temp_neg || (temp_bcd <= CRIT_CLR);
    assign rate_fault = (rate_bcd >= RATE_TH);
    assign sign_fault = sref_valid_q && (temp_neg != sref_q);
    assign fault_hit  = rate_fault || sign_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= NORMAL;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            sref_q       <= 1'b0;
            sref_valid_q <= 1'b0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b1;
            bcd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            sref_q       <= sref_d;
            sref_valid_q <= sref_valid_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            bcd_err_q    <= sample_valid && !in_ok;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        sref_d       = sref_q;
        sref_valid_d = sref_valid_q;
        cond_a       = 1'b0;
        cond_b       = 1'b0;
        tgt_a        = state_q;
        tgt_b        = state_q;
        hit          = 1'b0;
        pend_n       = pend_q;

        // per state: target A (pend=1) has priority over target B (pend=0)
        case (state_q)
            NORMAL: begin
                cond_a = gt_crit;  tgt_a = CRIT;
                cond_b = gt_warn;  tgt_b = WARN;
            end
            WARN: begin
                cond_a = gt_crit;  tgt_a = CRIT;
                cond_b = le_wclr;  tgt_b = NORMAL;
            end
            CRIT: begin
                cond_a = 1'b0;     tgt_a = CRIT;
                cond_b = le_cclr;  tgt_b = WARN;
            end
            default: begin
                cond_a = 1'b0;
                cond_b = 1'b0;
            end
        endcase

        if (state_q == FAULT) begin
            if (ack && !(accepted && fault_hit)) begin
                state_d      = NORMAL;
                cnt_d        = '0;
                pend_d       = 1'b0;
                sref_valid_d = 1'b0;
            end
        end else if (accepted) begin
            if (!sref_valid_q) begin
                sref_valid_d = 1'b1;
                sref_d       = temp_neg;
            end
            if (fault_hit) begin
                state_d = FAULT;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end else begin
                // an idle counter picks the pending target; afterwards only it may continue
                if (cnt_q == '0) begin
                    hit    = cond_a || cond_b;
                    pend_n = cond_a;
                end else begin
                    hit    = pend_q ? cond_a : cond_b;
                    pend_n = pend_q;
                end
                if (!hit) begin
                    cnt_d  = '0;
                    pend_d = 1'b0;
                end else if (cnt_q == P_LAST) begin
                    state_d = pend_n ? tgt_a : tgt_b;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    pend_d = pend_n;
                end
            end
        end
    end

    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b1;
        if (state_q == CRIT && state_d == CRIT) begin
            if (blink_cnt_q == B_LAST) begin
                blink_cnt_d = '0;
                phase_d     = !phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
    end

    always_comb begin
        alarm = '0;
        case (state_q)
            WARN:    alarm = WARN_PAT;
            CRIT:    alarm = phase_q ? '1 : '0;
            FAULT:   alarm = '1;
            default: alarm = '0;
        endcase
    end

    assign state   = state_q;
    assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_temp_alarm_fsm.sv
// Directed scoreboard bench for temp_alarm_fsm (PERSIST=4, BLINK_DIV=4, 3 digits).
module tb_temp_alarm_fsm;

    localparam logic [9:0] AL_OFF  = 10'b0000000000;
    localparam logic [9:0] AL_ON   = 10'b1111111111;
    localparam logic [9:0] AL_WARN = 10'b1010101010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] temp_bcd = '0;
    logic        temp_neg = 1'b0;
    logic [11:0] rate_bcd = '0;
    logic        ack = 1'b0;
    logic [9:0]  alarm;
    logic [1:0]  state;
    logic        bcd_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [9:0] al;
        logic       err;
    } exp_t;

    exp_t sb[$];

    temp_alarm_fsm #(
        .DIGITS(3), .LEDS(10),
        .WARN_TH(12'h460), .WARN_CLR(12'h450),
        .CRIT_TH(12'h490), .CRIT_CLR(12'h480),
        .RATE_TH(12'h050), .PERSIST(4), .BLINK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .temp_bcd(temp_bcd), .temp_neg(temp_neg), .rate_bcd(rate_bcd),
        .ack(ack), .alarm(alarm), .state(state), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    // blink phase is 1 for cycles 0..3 after CRIT entry, 0 for 4..7, and so on
    function automatic logic [9:0] crit_alarm(input int k);
        return (((k / 4) % 2) == 0) ? AL_ON : AL_OFF;
    endfunction

    task automatic step(input logic sv, input logic [11:0] t, input logic n,
                        input logic [11:0] r, input logic a, input logic rs,
                        input logic [1:0] es, input logic [9:0] ea, input logic ee,
                        input string tag);
        exp_t e;
        exp_t got;
        sample_valid = sv;
        temp_bcd     = t;
        temp_neg     = n;
        rate_bcd     = r;
        ack          = a;
        rst          = rs;
        e.tag = tag;
        e.st  = es;
        e.al  = ea;
        e.err = ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        assert (state === got.st) else begin
            failures++;
            $error("FAIL %s state got=%b exp=%b", got.tag, state, got.st);
        end
        checks++;
        assert (alarm === got.al) else begin
            failures++;
            $error("FAIL %s alarm got=%b exp=%b", got.tag, alarm, got.al);
        end
        checks++;
        assert (bcd_err === got.err) else begin
            failures++;
            $error("FAIL %s bcd_err got=%b exp=%b", got.tag, bcd_err, got.err);
        end
    endtask

    task automatic smp(input logic [11:0] t, input logic n, input logic [11:0] r,
                       input logic [1:0] es, input logic [9:0] ea, input string tag);
        step(1'b1, t, n, r, 1'b0, 1'b0, es, ea, 1'b0, tag);
    endtask

    task automatic idle(input logic [1:0] es, input logic [9:0] ea, input string tag);
        step(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, es, ea, 1'b0, tag);
    endtask

    initial begin
        // reset, including override of a coincident sample
        step(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 2'b00, AL_OFF, 1'b0, "reset");
        step(1'b1, 12'h470, 1'b0, 12'h000, 1'b0, 1'b1, 2'b00, AL_OFF, 1'b0, "reset_override");

        for (int i = 0; i < 3; i++) smp(12'h470, 1'b0, 12'h000, 2'b00, AL_OFF, "warn_pre");
        smp(12'h470, 1'b0, 12'h000, 2'b01, AL_WARN, "warn_entry");

        for (int i = 0; i < 3; i++) smp(12'h495, 1'b0, 12'h000, 2'b01, AL_WARN, "crit_pre");
        smp(12'h495, 1'b0, 12'h000, 2'b10, crit_alarm(0), "crit_entry");
        for (int k = 1; k <= 8; k++) idle(2'b10, crit_alarm(k), "blink");
        for (int i = 0; i < 4; i++) smp(12'h485, 1'b0, 12'h000, 2'b10, crit_alarm(9 + i), "crit_hyst");
        for (int i = 0; i < 3; i++) smp(12'h480, 1'b0, 12'h000, 2'b10, crit_alarm(13 + i), "crit_clr_pre");
        smp(12'h480, 1'b0, 12'h000, 2'b01, AL_WARN, "crit_to_warn");

        for (int i = 0; i < 3; i++) smp(12'h440, 1'b0, 12'h000, 2'b01, AL_WARN, "warn_clr_pre");
        smp(12'h440, 1'b0, 12'h000, 2'b00, AL_OFF, "warn_to_normal");

        for (int i = 0; i < 4; i++) smp(12'h460, 1'b0, 12'h000, 2'b00, AL_OFF, "at_warn_th");

        // broken CRIT run restarts the counter rather than completing WARN
        smp(12'h495, 1'b0, 12'h000, 2'b00, AL_OFF, "restart_a");
        smp(12'h495, 1'b0, 12'h000, 2'b00, AL_OFF, "restart_b");
        smp(12'h470, 1'b0, 12'h000, 2'b00, AL_OFF, "restart_c");
        smp(12'h495, 1'b0, 12'h000, 2'b00, AL_OFF, "restart_d");
        smp(12'h495, 1'b0, 12'h000, 2'b00, AL_OFF, "restart_e");
        smp(12'h495, 1'b0, 12'h000, 2'b00, AL_OFF, "restart_f");
        smp(12'h495, 1'b0, 12'h000, 2'b10, crit_alarm(0), "restart_crit");

        for (int k = 1; k <= 3; k++) smp(12'h440, 1'b0, 12'h000, 2'b10, crit_alarm(k), "no_direct_pre");
        smp(12'h440, 1'b0, 12'h000, 2'b01, AL_WARN, "no_direct_normal");
        for (int i = 0; i < 3; i++) smp(12'h440, 1'b0, 12'h000, 2'b01, AL_WARN, "back_pre");
        smp(12'h440, 1'b0, 12'h000, 2'b00, AL_OFF, "back_normal");

        // sign reference fault and ack
        smp(12'h300, 1'b0, 12'h000, 2'b00, AL_OFF, "sign_same");
        smp(12'h100, 1'b1, 12'h000, 2'b11, AL_ON, "sign_fault");
        smp(12'h300, 1'b0, 12'h000, 2'b11, AL_ON, "fault_hold");
        step(1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 2'b00, AL_OFF, 1'b0, "ack_clear");
        smp(12'h100, 1'b1, 12'h000, 2'b00, AL_OFF, "ref_reload");
        smp(12'h100, 1'b1, 12'h000, 2'b00, AL_OFF, "ref_match");
        step(1'b1, 12'h470, 1'b1, 12'h000, 1'b1, 1'b0, 2'b00, AL_OFF, 1'b0, "ack_ignored");

        // rate fault, rejected sample, ack vs coincident fault
        smp(12'h300, 1'b1, 12'h050, 2'b11, AL_ON, "rate_fault");
        step(1'b1, 12'h4A0, 1'b1, 12'h000, 1'b0, 1'b0, 2'b11, AL_ON, 1'b1, "bcd_reject");
        idle(2'b11, AL_ON, "bcd_pulse_end");
        step(1'b1, 12'h300, 1'b1, 12'h060, 1'b1, 1'b0, 2'b11, AL_ON, 1'b0, "ack_vs_fault");
        step(1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 2'b00, AL_OFF, 1'b0, "ack_clear2");

        // rejected sample leaves the persistence count intact
        for (int i = 0; i < 3; i++) smp(12'h470, 1'b0, 12'h000, 2'b00, AL_OFF, "bcd_count_pre");
        step(1'b1, 12'h470, 1'b0, 12'h0A0, 1'b0, 1'b0, 2'b00, AL_OFF, 1'b1, "bcd_rate_reject");
        smp(12'h470, 1'b0, 12'h000, 2'b01, AL_WARN, "bcd_no_disturb");
        smp(12'h455, 1'b0, 12'h049, 2'b01, AL_WARN, "rate_below_th");

        // reset mid-CRIT and mid-FAULT
        for (int i = 0; i < 3; i++) smp(12'h495, 1'b0, 12'h000, 2'b01, AL_WARN, "crit2_pre");
        smp(12'h495, 1'b0, 12'h000, 2'b10, crit_alarm(0), "crit2_entry");
        idle(2'b10, crit_alarm(1), "crit2_idle");
        step(1'b1, 12'h495, 1'b0, 12'h000, 1'b0, 1'b1, 2'b00, AL_OFF, 1'b0, "rst_in_crit");
        smp(12'h470, 1'b0, 12'h000, 2'b00, AL_OFF, "post_rst");
        smp(12'h300, 1'b0, 12'h090, 2'b11, AL_ON, "fault2");
        step(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 2'b00, AL_OFF, 1'b0, "rst_in_fault");
        rst = 1'b0;
        idle(2'b00, AL_OFF, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
